elastic_skid: RTL

ELASTIC_SKID -- requirements
Module: elastic_skid

---
 rtl/elastic_skid.sv | 98 +++++++++
 1 files changed

// File: rtl/elastic_skid.sv
// Two-entry elastic skid buffer: fully registered valid/ready handshake with
// strict FIFO ordering, one-cycle latency and full throughput.
module elastic_skid #(
  parameter int unsigned width_p          = 8,
  parameter bit          datapath_reset_p = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [1:0]         count_o
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic [width_p-1:0] main_q, main_d;
  logic [width_p-1:0] skid_q, skid_d;
  logic               in_xfer, out_xfer;

  assign in_xfer  = valid_i & ready_q;
  assign out_xfer = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (valid_i) begin
          main_d  = data_i;
          state_d = StOne;
        end
      end
      StOne: begin
        if (in_xfer && out_xfer) begin
          main_d = data_i;
        end else if (in_xfer) begin
          skid_d  = data_i;
          state_d = StFull;
        end else if (out_xfer) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (ready_i) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // ready_o is registered: precompute it from the next state.
    ready_d = (state_d != StFull);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= StEmpty;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  if (datapath_reset_p) begin : g_data_rst
    always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
        main_q <= '0;
        skid_q <= '0;
      end else begin
        main_q <= main_d;
        skid_q <= skid_d;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk_i) begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = (state_q == StOne) || (state_q == StFull);
  assign data_o  = main_q;
  assign count_o = state_q;

endmodule
